// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the writeback scheduler: register index and buffered writeback entry.
// Pure type/constant package; no logic, no latency, no flow control.
package regfile_ctrl_pkg;
    localparam int REG_CNT = 8;
    localparam int REG_AW  = $clog2(REG_CNT);
    localparam int DATA_W  = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback and register-file write bundle of the writeback scheduler.
// Wiring only; stall is the single backpressure signal back to decode.
interface regfile_wb_scheduler_if
    import regfile_ctrl_pkg::*;
#(
    parameter int D_SIZE    = DATA_W,
    parameter int BUF_DEPTH = 2
) ();
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic               issue_valid;
    logic               issue_dest_en;
    reg_idx_t           issue_dest;
    logic               issue_src1_en;
    reg_idx_t           issue_src1;
    logic               issue_src2_en;
    reg_idx_t           issue_src2;
    logic               stall;

    logic               alu_wb_valid;
    reg_idx_t           alu_wb_dest;
    logic [D_SIZE-1:0]  alu_wb_data;
    logic               ld_wb_valid;
    reg_idx_t           ld_wb_dest;
    logic [D_SIZE-1:0]  ld_wb_data;

    logic               write_en;
    reg_idx_t           dest_wb;
    logic [D_SIZE-1:0]  result_wb;
    logic [REG_CNT-1:0] pending;
    logic [CNT_W-1:0]   buf_count;
    logic               err;

    modport master (
        output issue_valid, issue_dest_en, issue_dest, issue_src1_en, issue_src1,
               issue_src2_en, issue_src2,
               alu_wb_valid, alu_wb_dest, alu_wb_data, ld_wb_valid, ld_wb_dest, ld_wb_data,
        input  stall, write_en, dest_wb, result_wb, pending, buf_count, err
    );

    modport slave (
        input  issue_valid, issue_dest_en, issue_dest, issue_src1_en, issue_src1,
               issue_src2_en, issue_src2,
               alu_wb_valid, alu_wb_dest, alu_wb_data, ld_wb_valid, ld_wb_dest, ld_wb_data,
        output stall, write_en, dest_wb, result_wb, pending, buf_count, err
    );
endinterface

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// FIFO of deferred ALU writebacks; head visible combinationally, push/pop take effect at the edge.
// Push while full is dropped unless a pop happens in the same cycle.
module wb_fifo
    import regfile_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  wb_entry_t        i_dat,
    output wb_entry_t        o_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dat     = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (load > buffered ALU > direct ALU) with pending-write scoreboard.
// One-cycle registered write output; decode stalls on RAW/WAW hazards or a full ALU buffer.
module regfile_wb_scheduler
    import regfile_ctrl_pkg::*;
#(
    parameter int D_SIZE    = DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input logic                    clk,
    input logic                    reset,
    regfile_wb_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [REG_CNT-1:0] r_pending;
    logic               r_write_en;
    reg_idx_t           r_dest_wb;
    logic [D_SIZE-1:0]  r_result_wb;
    logic               r_err;

    wb_entry_t          w_alu_entry;
    wb_entry_t          w_head;
    wb_entry_t          w_sel;
    logic               w_sel_vld;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_raw;
    logic               w_waw;
    logic               w_stall;
    logic               w_accept;
    logic               w_err_set;
    logic [REG_CNT-1:0] w_pending_nxt;

    assign w_alu_entry = '{dest: bus.alu_wb_dest, data: bus.alu_wb_data};

    wb_fifo #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_alu_entry),
        .o_dat   (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = w_alu_entry;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        if (bus.ld_wb_valid) begin
            w_sel_vld = 1'b1;
            w_sel     = '{dest: bus.ld_wb_dest, data: bus.ld_wb_data};
            w_push    = bus.alu_wb_valid;
        end else if (!w_empty) begin
            w_sel_vld = 1'b1;
            w_sel     = w_head;
            w_pop     = 1'b1;
            w_push    = bus.alu_wb_valid;
        end else if (bus.alu_wb_valid) begin
            w_sel_vld = 1'b1;
        end
    end

    assign w_raw    = (bus.issue_src1_en & r_pending[bus.issue_src1]) |
                      (bus.issue_src2_en & r_pending[bus.issue_src2]);
    assign w_waw    = bus.issue_dest_en & r_pending[bus.issue_dest];
    assign w_stall  = reset & (w_raw | w_waw | w_full);
    assign w_accept = bus.issue_valid & ~w_stall;

    // Clear first so a forced same-register set in the same cycle wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_write_en)                       w_pending_nxt[r_dest_wb]      = 1'b0;
        if (w_accept && bus.issue_dest_en)    w_pending_nxt[bus.issue_dest] = 1'b1;
    end

    assign w_err_set = (w_push & w_full & ~w_pop) |
                       (r_write_en & ~r_pending[r_dest_wb]) |
                       (bus.ld_wb_valid & bus.alu_wb_valid & w_full);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending   <= '0;
            r_write_en  <= 1'b0;
            r_dest_wb   <= '0;
            r_result_wb <= '0;
            r_err       <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_write_en <= w_sel_vld;
            if (w_sel_vld) begin
                r_dest_wb   <= w_sel.dest;
                r_result_wb <= w_sel.data;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.write_en  = r_write_en;
    assign bus.dest_wb   = r_dest_wb;
    assign bus.result_wb = r_result_wb;
    assign bus.pending   = r_pending;
    assign bus.buf_count = w_count;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, RAW/WAW stalls, collisions, buffer fill and reset mid-drain.
module tb_regfile_wb_scheduler;
    import regfile_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.D_SIZE(32), .BUF_DEPTH(2)) bus ();

    regfile_wb_scheduler #(.D_SIZE(32), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_dest  = '0;
        bus.alu_wb_data  = '0;
        bus.ld_wb_valid  = 1'b0;
        bus.ld_wb_dest   = '0;
        bus.ld_wb_data   = '0;
    endtask

    task automatic idle_issue();
        bus.issue_valid   = 1'b0;
        bus.issue_dest_en = 1'b0;
        bus.issue_dest    = '0;
        bus.issue_src1_en = 1'b0;
        bus.issue_src1    = '0;
        bus.issue_src2_en = 1'b0;
        bus.issue_src2    = '0;
    endtask

    task automatic issue_dest(input int d);
        bus.issue_valid   = 1'b1;
        bus.issue_dest_en = 1'b1;
        bus.issue_dest    = reg_idx_t'(d);
        cyc();
        idle_issue();
    endtask

    task automatic both_wb(input int ld_d, input logic [31:0] ld_v, input int alu_d, input logic [31:0] alu_v);
        bus.ld_wb_valid  = 1'b1;
        bus.ld_wb_dest   = reg_idx_t'(ld_d);
        bus.ld_wb_data   = ld_v;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_dest  = reg_idx_t'(alu_d);
        bus.alu_wb_data  = alu_v;
    endtask

    initial begin
        int ld_d  [3] = '{0, 2, 3};
        int alu_d [3] = '{1, 4, 6};
        int fill_d[6] = '{0, 1, 2, 3, 4, 6};

        idle_issue();
        idle_wb();

        // Reset then idle
        reset = 1'b0;
        cyc();
        cyc();
        chk("stall_in_reset", bus.stall, 0);
        reset = 1'b1;
        cyc();
        chk("rst_write_en", bus.write_en, 0);
        chk("rst_pending", bus.pending, 8'h00);
        chk("rst_buf_count", bus.buf_count, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_dest_wb", bus.dest_wb, 0);
        chk("rst_result_wb", bus.result_wb, 0);

        // RAW stall on r3
        bus.issue_valid   = 1'b1;
        bus.issue_dest_en = 1'b1;
        bus.issue_dest    = 3'd3;
        #1 chk("raw_first_issue_stall", bus.stall, 0);
        cyc();
        bus.issue_dest_en = 1'b0;
        bus.issue_src1_en = 1'b1;
        bus.issue_src1    = 3'd3;
        #1 chk("raw_stall", bus.stall, 1);
        chk("raw_pending", bus.pending, 8'h08);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_dest  = 3'd3;
        bus.alu_wb_data  = 32'h0000_0033;
        cyc();
        idle_wb();
        #1 chk("raw_we", bus.write_en, 1);
        chk("raw_dest", bus.dest_wb, 3);
        chk("raw_data", bus.result_wb, 32'h0000_0033);
        chk("raw_stall_during_write", bus.stall, 1);
        cyc();
        chk("raw_unstall", bus.stall, 0);
        chk("raw_pending_clr", bus.pending, 8'h00);
        chk("raw_we_off", bus.write_en, 0);
        idle_issue();

        // Load/ALU collision
        issue_dest(2);
        issue_dest(5);
        chk("col_pending", bus.pending, 8'h24);
        both_wb(2, 32'hAAAA_0000, 5, 32'h0000_0055);
        cyc();
        idle_wb();
        #1 chk("col_we1", bus.write_en, 1);
        chk("col_dest1", bus.dest_wb, 2);
        chk("col_data1", bus.result_wb, 32'hAAAA_0000);
        chk("col_buf1", bus.buf_count, 1);
        cyc();
        chk("col_we2", bus.write_en, 1);
        chk("col_dest2", bus.dest_wb, 5);
        chk("col_data2", bus.result_wb, 32'h0000_0055);
        chk("col_buf0", bus.buf_count, 0);
        chk("col_pending_mid", bus.pending, 8'h20);
        cyc();
        chk("col_we_off", bus.write_en, 0);
        chk("col_pending_clr", bus.pending, 8'h00);
        chk("col_err", bus.err, 0);

        // Buffer fill and overflow
        for (int i = 0; i < 6; i++) issue_dest(fill_d[i]);
        chk("fill_pending", bus.pending, 8'h5F);
        both_wb(ld_d[0], 32'h1000_0000, alu_d[0], 32'hA000_0001);
        cyc();
        chk("fill1_dest", bus.dest_wb, 0);
        chk("fill1_buf", bus.buf_count, 1);
        chk("fill1_stall", bus.stall, 0);
        chk("fill1_err", bus.err, 0);
        both_wb(ld_d[1], 32'h1000_0002, alu_d[1], 32'hA000_0004);
        cyc();
        chk("fill2_dest", bus.dest_wb, 2);
        chk("fill2_buf", bus.buf_count, 2);
        chk("fill2_stall", bus.stall, 1);
        chk("fill2_err", bus.err, 0);
        both_wb(ld_d[2], 32'h1000_0003, alu_d[2], 32'hA000_0006);
        cyc();
        idle_wb();
        #1 chk("fill3_dest", bus.dest_wb, 3);
        chk("fill3_buf", bus.buf_count, 2);
        chk("fill3_err", bus.err, 1);
        cyc();
        chk("drain1_we", bus.write_en, 1);
        chk("drain1_dest", bus.dest_wb, 1);
        chk("drain1_data", bus.result_wb, 32'hA000_0001);
        chk("drain1_buf", bus.buf_count, 1);
        chk("drain1_stall", bus.stall, 0);
        cyc();
        chk("drain2_dest", bus.dest_wb, 4);
        chk("drain2_data", bus.result_wb, 32'hA000_0004);
        chk("drain2_buf", bus.buf_count, 0);
        cyc();
        chk("drain_done_we", bus.write_en, 0);
        chk("drain_pending", bus.pending, 8'h40);

        // Reset mid-drain
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rst2_err", bus.err, 0);
        issue_dest(1);
        issue_dest(4);
        both_wb(0, 32'h2000_0000, 1, 32'hB000_0001);
        cyc();
        both_wb(0, 32'h2000_0001, 4, 32'hB000_0004);
        cyc();
        idle_wb();
        #1 chk("mid_buf", bus.buf_count, 2);
        chk("mid_pending", bus.pending, 8'h12);
        reset = 1'b0;
        cyc();
        chk("mid_rst_buf", bus.buf_count, 0);
        chk("mid_rst_pending", bus.pending, 8'h00);
        chk("mid_rst_we", bus.write_en, 0);
        reset = 1'b1;
        cyc();
        chk("mid_post_we1", bus.write_en, 0);
        chk("mid_post_buf", bus.buf_count, 0);
        cyc();
        chk("mid_post_we2", bus.write_en, 0);

        // WAW stall and spurious write
        issue_dest(7);
        chk("waw_pending", bus.pending, 8'h80);
        bus.issue_valid   = 1'b1;
        bus.issue_dest_en = 1'b1;
        bus.issue_dest    = 3'd7;
        #1 chk("waw_stall", bus.stall, 1);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_dest  = 3'd0;
        bus.alu_wb_data  = 32'h1234_5678;
        cyc();
        idle_wb();
        #1 chk("spur_we", bus.write_en, 1);
        chk("spur_dest", bus.dest_wb, 0);
        chk("spur_data", bus.result_wb, 32'h1234_5678);
        chk("spur_err_pre", bus.err, 0);
        cyc();
        chk("spur_err", bus.err, 1);
        chk("spur_pending", bus.pending, 8'h80);
        chk("waw_still_stall", bus.stall, 1);
        reset = 1'b0;
        #1 chk("stall_zero_in_reset", bus.stall, 0);
        cyc();
        reset = 1'b1;
        idle_issue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
